// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit and the decoder that drives it.
// Holds the mdu op codes, the FSM state encoding and the ALU-op to mdu-op mapping.
// No logic of its own: no latency and no backpressure.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } mdu_state_e;

    // ALU function codes the decoder sees for HI/LO-writing instructions.
    localparam logic [5:0] ALU_MULT  = 6'h18;
    localparam logic [5:0] ALU_MULTU = 6'h19;
    localparam logic [5:0] ALU_DIV   = 6'h1A;
    localparam logic [5:0] ALU_DIVU  = 6'h1B;

    function automatic mdu_op_e alu_to_mdu_op(input logic [5:0] alu_op);
        mdu_op_e res;
        case (alu_op)
            ALU_MULTU: res = MDU_MULTU;
            ALU_DIV:   res = MDU_DIV;
            ALU_DIVU:  res = MDU_DIVU;
            default:   res = MDU_MULT;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// Pure wiring: no latency; backpressure is the busy level seen by the requester.
// master = pipeline side (start/op/a/b/flush), slave = the unit (busy/done/results).
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result_hi, result_lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result_hi, result_lo, div_by_zero
    );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the unsigned multiply/divide datapath (shift-add or restoring subtract).
// Purely combinational: zero latency.
// No handshake; the caller decides when to register the result.
// Ports: is_div selects the operation; hi/lo are the 2W working register, b the magnitude
// of the multiplicand/divisor; hi_nxt/lo_nxt the register value after this step.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic           ge;

    always_comb begin
        // Multiply: lo holds the remaining multiplier bits, hi the partial product.
        sum     = {1'b0, hi} + ({1'b0, b} & {(WIDTH+1){lo[0]}});
        // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
        shifted = {hi, lo[WIDTH-1]};
        ge      = (shifted >= {1'b0, b});
        if (is_div) begin
            // When ge the difference is below b, so it fits in WIDTH bits.
            hi_nxt = ge ? (shifted[WIDTH-1:0] - b) : shifted[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], ge};
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned multiply and divide, one bit per cycle, for the EX stage.
// Latency: done WIDTH+1 cycles after the accepting edge (1 cycle for divide by zero).
// Backpressure: busy stalls the pipeline; start outside IDLE is dropped; flush aborts.
// Ports: clk/rst (sync, active-high) plus the slave side of mul_div_unit_if.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    mul_div_unit_if.slave   bus
);
    mdu_state_e       state;
    mdu_state_e       state_nxt;
    logic             busy;
    logic             done;

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] mag_b_r;
    logic             div_r;
    logic             neg_q_r;     // negate product / quotient at the end
    logic             neg_r_r;     // negate remainder at the end (dividend was negative)

    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             dbz_r;

    logic             is_div;
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             b_zero;
    logic             accept;
    logic             last;
    logic             finish;

    logic [WIDTH-1:0]   hi_nxt;
    logic [WIDTH-1:0]   lo_nxt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    always_comb begin
        is_div    = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
        is_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
        a_neg     = is_signed & bus.a[WIDTH-1];
        b_neg     = is_signed & bus.b[WIDTH-1];
        // -2^(W-1) negates to itself, which read as unsigned is the correct magnitude.
        mag_a     = a_neg ? -bus.a : bus.a;
        mag_b     = b_neg ? -bus.b : bus.b;
        b_zero    = (bus.b == '0);
        accept    = (state == S_IDLE) && bus.start && !bus.flush;
        last      = (count == CNT_W'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = (is_div && b_zero) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (bus.flush) state_nxt = S_IDLE;
    end

    // Results are committed only on a real CALC->DONE transition, so a flush on the
    // final iteration leaves the previously held values intact.
    assign finish = (state == S_CALC) && (state_nxt == S_DONE);

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div (div_r),
        .hi     (hi_r),
        .lo     (lo_r),
        .b      (mag_b_r),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    // Sign fix-up on the value produced by the final iteration.
    always_comb begin
        prod_fix = neg_q_r ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
        q_fix    = neg_q_r ? -lo_nxt : lo_nxt;
        r_fix    = neg_r_r ? -hi_nxt : hi_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            mag_b_r <= '0;
            div_r   <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            res_hi  <= '0;
            res_lo  <= '0;
            dbz_r   <= 1'b0;
        end else if (accept) begin
            count   <= '0;
            hi_r    <= '0;
            lo_r    <= mag_a;
            mag_b_r <= mag_b;
            div_r   <= is_div;
            neg_q_r <= a_neg ^ b_neg;
            neg_r_r <= is_div & a_neg;
            if (is_div && b_zero) begin
                res_hi <= bus.a;
                res_lo <= '1;
                dbz_r  <= 1'b1;
            end
        end else if (state == S_CALC) begin
            hi_r  <= hi_nxt;
            lo_r  <= lo_nxt;
            count <= count + 1'b1;
            if (finish) begin
                dbz_r <= 1'b0;
                if (div_r) begin
                    res_hi <= r_fix;
                    res_lo <= q_fix;
                end else begin
                    res_hi <= prod_fix[2*WIDTH-1:WIDTH];
                    res_lo <= prod_fix[WIDTH-1:0];
                end
            end
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.result_hi   = res_hi;
    assign bus.result_lo   = res_lo;
    assign bus.div_by_zero = dbz_r;

endmodule
